// File: rtl/present_decrypt_control.sv
// PRESENT-80 decryption sequencer: forward key expansion to K32, then
// ROUNDS inverse rounds back down to K1, then one output whitening strobe.
module present_decrypt_control #(
    parameter int ROUNDS = 31
) (
    input  logic       inClk,
    input  logic       inRst,
    input  logic       inKeyExtWr,
    input  logic       inExtDataWr,
    output logic       outStateExtWr,
    output logic       outStateIntWr,
    output logic       outKeyExtWr,
    output logic       outKeyIntWr,
    output logic       outKeyInvSel,
    output logic       outDataIntWr,
    output logic [4:0] outRoundCounter,
    output logic       outBusy
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DECRYPT,
        FINISH
    } state_t;

    localparam logic [4:0] LAST = 5'(ROUNDS);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (inExtDataWr) begin
                    state_d = EXPAND;
                    cnt_d   = 5'd1;
                end
            end
            EXPAND: begin
                // counter holds at ROUNDS: first inverse round uses K32
                if (cnt_q == LAST) state_d = DECRYPT;
                else               cnt_d   = cnt_q + 5'd1;
            end
            DECRYPT: begin
                if (cnt_q == 5'd1) begin
                    state_d = FINISH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        outStateExtWr   = 1'b0;
        outStateIntWr   = 1'b0;
        outKeyExtWr     = 1'b0;
        outKeyIntWr     = 1'b0;
        outKeyInvSel    = 1'b0;
        outDataIntWr    = 1'b0;
        outRoundCounter = '0;
        outBusy         = 1'b0;
        if (!inRst) begin
            case (state_q)
                IDLE: begin
                    outStateExtWr = inExtDataWr;
                    outKeyExtWr   = inExtDataWr & inKeyExtWr;
                end
                EXPAND: begin
                    outKeyIntWr     = 1'b1;
                    outRoundCounter = cnt_q;
                    outBusy         = 1'b1;
                end
                DECRYPT: begin
                    outStateIntWr   = 1'b1;
                    outKeyIntWr     = 1'b1;
                    outKeyInvSel    = 1'b1;
                    outRoundCounter = cnt_q;
                    outBusy         = 1'b1;
                end
                FINISH: begin
                    outDataIntWr = 1'b1;
                    outBusy      = 1'b1;
                end
                default: begin
                    outBusy = 1'b0;
                end
            endcase
        end
    end

endmodule
